keypad_scanner: RTL and testbench

//   Scans a 6-row x 4-column matrix keypad, debounces one key at a time and turns each

---
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 6-row x 4-column active-low matrix keypad.
// It debounces one key at a time and turns each accepted press into a
// single-cycle event. Press and release both need DEBOUNCE matching samples.
// Ports:
//   clock    - system clock, all logic on posedge
//   reset    - synchronous active-high reset
//   col_n    - keypad columns, active-low, asynchronous to clock
//   row_n    - keypad row drive, active-low one-cold
//   newhex   - 1-cycle pulse, hex key accepted; hexcode holds its value
//   newop    - 1-cycle pulse, operator key accepted; opcode holds it
//   eq/BS/clr- 1-cycle pulses for equals, backspace, clear
//   key_down - high while a key is being debounced or is held
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 8,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [5:0] row_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       BS,
  output logic       clr,
  output logic       key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_ROW   = 3'd5;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]       col_s1, col_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       row_idx, row_idx_nx;
  logic [1:0]       state, state_nx;
  logic [1:0]       key_col, key_col_nx;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nx;
  logic [CNT_W-1:0] rel_cnt, rel_cnt_nx;

  logic       sample, low_any, accept, advance;
  logic [1:0] low_col;

  logic       newhex_nx, newop_nx, eq_nx, bs_nx, clr_nx, key_down_nx;
  logic [3:0] hexcode_nx;
  logic [1:0] opcode_nx;

  assign sample = (div_cnt == DIV_LAST);

  // Lowest-index low column on the synchronised inputs wins.
  always_comb begin
    low_any = ~&col_s2;
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s2[i]) low_col = 2'(i);
    end
  end

  // Next-state logic: scan / debounce / held.
  always_comb begin
    state_nx   = state;
    row_idx_nx = row_idx;
    key_col_nx = key_col;
    deb_cnt_nx = deb_cnt;
    rel_cnt_nx = rel_cnt;
    accept     = 1'b0;
    advance    = 1'b0;

    case (state)
      ST_SCAN: begin
        if (sample) begin
          if (low_any) begin
            key_col_nx = low_col;
            deb_cnt_nx = CNT_ONE;
            if (DEB_TARGET == CNT_ONE) begin
              accept     = 1'b1;
              rel_cnt_nx = '0;
              state_nx   = ST_HELD;
            end else begin
              state_nx = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (low_any && (low_col == key_col)) begin
            deb_cnt_nx = deb_cnt + CNT_ONE;
            if ((deb_cnt + CNT_ONE) == DEB_TARGET) begin
              accept     = 1'b1;
              rel_cnt_nx = '0;
              state_nx   = ST_HELD;
            end
          end else begin
            deb_cnt_nx = '0;
            advance    = 1'b1;
            state_nx   = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        // Any low column on the held row (including extra keys) blocks release.
        if (sample) begin
          if (!low_any) begin
            rel_cnt_nx = rel_cnt + CNT_ONE;
            if ((rel_cnt + CNT_ONE) == DEB_TARGET) begin
              rel_cnt_nx = '0;
              advance    = 1'b1;
              state_nx   = ST_SCAN;
            end
          end else begin
            rel_cnt_nx = '0;
          end
        end
      end
      default: begin
        state_nx   = ST_SCAN;
        row_idx_nx = 3'd0;
      end
    endcase

    if (advance) begin
      row_idx_nx = (row_idx == LAST_ROW) ? 3'd0 : row_idx + 3'd1;
    end
  end

  // Event decode; on accept the driven row is still the key's row.
  always_comb begin
    newhex_nx  = 1'b0;
    newop_nx   = 1'b0;
    eq_nx      = 1'b0;
    bs_nx      = 1'b0;
    clr_nx     = 1'b0;
    hexcode_nx = hexcode;
    opcode_nx  = opcode;
    if (accept) begin
      case (row_idx)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          newhex_nx  = 1'b1;
          hexcode_nx = {row_idx[1:0], low_col};
        end
        3'd4: begin
          newop_nx  = 1'b1;
          opcode_nx = low_col;
        end
        3'd5: begin
          case (low_col)
            2'd0:    eq_nx  = 1'b1;
            2'd1:    bs_nx  = 1'b1;
            2'd2:    clr_nx = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    key_down_nx = (state_nx == ST_DEBOUNCE) || (state_nx == ST_HELD);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_SCAN;
    end else begin
      state <= state_nx;
    end
  end

  // Synchroniser, dwell counter, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_s1   <= 4'b1111;
      col_s2   <= 4'b1111;
      div_cnt  <= '0;
      row_idx  <= 3'd0;
      row_n    <= 6'b111110;
      key_col  <= 2'd0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
      newhex   <= 1'b0;
      hexcode  <= 4'd0;
      newop    <= 1'b0;
      opcode   <= 2'd0;
      eq       <= 1'b0;
      BS       <= 1'b0;
      clr      <= 1'b0;
      key_down <= 1'b0;
    end else begin
      col_s1   <= col_n;
      col_s2   <= col_s1;
      div_cnt  <= sample ? '0 : div_cnt + DIV_W'(1);
      row_idx  <= row_idx_nx;
      row_n    <= ~(6'd1 << row_idx_nx);
      key_col  <= key_col_nx;
      deb_cnt  <= deb_cnt_nx;
      rel_cnt  <= rel_cnt_nx;
      newhex   <= newhex_nx;
      hexcode  <= hexcode_nx;
      newop    <= newop_nx;
      opcode   <= opcode_nx;
      eq       <= eq_nx;
      BS       <= bs_nx;
      clr      <= clr_nx;
      key_down <= key_down_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3).
// The keypad model pulls col_n[c] low iff key (r,c) is held and row r is driven.
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] col_n;
  logic [5:0] row_n;
  logic       newhex, newop, eq, BS, clr, key_down;
  logic [3:0] hexcode;
  logic [1:0] opcode;

  logic [5:0][3:0] keys;

  int checks   = 0;
  int failures = 0;

  int cyc = 0, n_hex = 0, n_op = 0, n_eq = 0, n_bs = 0, n_clr = 0;
  int n_multi = 0, n_badrow = 0, last_hex_cyc = 0;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
    .newhex(newhex), .hexcode(hexcode), .newop(newop), .opcode(opcode),
    .eq(eq), .BS(BS), .clr(clr), .key_down(key_down)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 6; r++) begin
      if (!row_n[r]) col_n = col_n & ~keys[r];
    end
  end

  // Pulse counters and invariant monitors, sampled on the falling edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (newhex === 1'b1) begin
      n_hex        <= n_hex + 1;
      last_hex_cyc <= cyc + 1;
    end
    if (newop === 1'b1) n_op  <= n_op + 1;
    if (eq === 1'b1)    n_eq  <= n_eq + 1;
    if (BS === 1'b1)    n_bs  <= n_bs + 1;
    if (clr === 1'b1)   n_clr <= n_clr + 1;
    if ((int'(newhex) + int'(newop) + int'(eq) + int'(BS) + int'(clr)) > 1)
      n_multi <= n_multi + 1;
    if ($countones(~row_n) != 1) n_badrow <= n_badrow + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (key_down === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_down(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (key_down === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = '0;
    step(3);
    checks++;
    if (row_n !== 6'b111110) begin
      failures++; $display("FAIL reset_row_n: got %b want 111110", row_n);
    end
    checks++;
    if ({newhex, newop, eq, BS, clr} !== 5'b0) begin
      failures++; $display("FAIL reset_pulses: got %b want 00000", {newhex, newop, eq, BS, clr});
    end
    checks++;
    if ({hexcode, opcode, key_down} !== 7'b0) begin
      failures++; $display("FAIL reset_codes: hexcode=%h opcode=%0d key_down=%b want 0/0/0", hexcode, opcode, key_down);
    end
    reset = 1'b0;
  endtask

  task automatic test_hex_press();
    int h0, o0, t0, lat;
    bit ok;
    h0 = n_hex;
    o0 = n_op + n_eq + n_bs + n_clr;
    step(1);
    t0 = cyc;
    keys[2][1] = 1'b1;
    step(100);
    checks++;
    if (n_hex - h0 !== 1) begin
      failures++; $display("FAIL hex_count: got %0d want 1", n_hex - h0);
    end
    checks++;
    if (hexcode !== 4'h9) begin
      failures++; $display("FAIL hex_code: got %h want 9", hexcode);
    end
    lat = last_hex_cyc - t0;
    checks++;
    if (lat < 1 || lat > 39) begin
      failures++; $display("FAIL hex_latency: got %0d want 1..39", lat);
    end
    checks++;
    if ((n_op + n_eq + n_bs + n_clr) - o0 !== 0) begin
      failures++; $display("FAIL hex_other_pulses: got %0d want 0", (n_op + n_eq + n_bs + n_clr) - o0);
    end
    keys = '0;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL hex_release: key_down got %b want 0", key_down);
    end
  endtask

  task automatic test_op_hold();
    int o0, x0;
    bit ok;
    o0 = n_op;
    x0 = n_hex + n_eq + n_bs + n_clr;
    keys[4][2] = 1'b1;
    step(500);
    checks++;
    if (n_op - o0 !== 1) begin
      failures++; $display("FAIL op_count: got %0d want 1", n_op - o0);
    end
    checks++;
    if (opcode !== 2'd2) begin
      failures++; $display("FAIL op_code: got %0d want 2", opcode);
    end
    checks++;
    if (key_down !== 1'b1) begin
      failures++; $display("FAIL op_key_down: got %b want 1", key_down);
    end
    checks++;
    if ((n_hex + n_eq + n_bs + n_clr) - x0 !== 0) begin
      failures++; $display("FAIL op_other_pulses: got %0d want 0", (n_hex + n_eq + n_bs + n_clr) - x0);
    end
    keys = '0;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL op_release: key_down got %b want 0", key_down);
    end
  endtask

  task automatic test_short_press();
    int p0;
    bit ok;
    p0 = n_hex + n_op + n_eq + n_bs + n_clr;
    keys[3][3] = 1'b1;
    wait_down(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL short_key_down: got %b want 1", key_down);
    end
    step(4);
    keys = '0;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL short_drop: key_down got %b want 0", key_down);
    end
    checks++;
    if (row_n !== 6'b101111) begin
      failures++; $display("FAIL short_row_advance: got %b want 101111", row_n);
    end
    step(20);
    checks++;
    if ((n_hex + n_op + n_eq + n_bs + n_clr) - p0 !== 0) begin
      failures++; $display("FAIL short_no_pulse: got %0d want 0", (n_hex + n_op + n_eq + n_bs + n_clr) - p0);
    end
  endtask

  task automatic test_two_keys();
    int h0, b0, x0;
    bit ok;
    h0 = n_hex;
    b0 = n_bs;
    x0 = n_op + n_eq + n_clr;
    keys[1][3] = 1'b1;
    keys[1][1] = 1'b1;
    step(100);
    checks++;
    if (n_hex - h0 !== 1) begin
      failures++; $display("FAIL two_hex_count: got %0d want 1", n_hex - h0);
    end
    checks++;
    if (hexcode !== 4'h5) begin
      failures++; $display("FAIL two_hex_code: got %h want 5", hexcode);
    end
    keys = '0;
    wait_idle(40, ok);
    keys[5][1] = 1'b1;
    step(100);
    checks++;
    if (n_bs - b0 !== 1) begin
      failures++; $display("FAIL bs_count: got %0d want 1", n_bs - b0);
    end
    checks++;
    if ((n_hex - h0 !== 1) || ((n_op + n_eq + n_clr) - x0 !== 0)) begin
      failures++; $display("FAIL bs_other_pulses: hex=%0d others=%0d want 1/0", n_hex - h0, (n_op + n_eq + n_clr) - x0);
    end
    keys = '0;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bs_release: key_down got %b want 0", key_down);
    end
  endtask

  task automatic test_reset_debounce();
    int h0;
    bit ok;
    h0 = n_hex;
    keys[0][0] = 1'b1;
    wait_down(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rstdeb_key_down: got %b want 1", key_down);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (row_n !== 6'b111110 || key_down !== 1'b0) begin
      failures++; $display("FAIL rstdeb_state: row_n=%b key_down=%b want 111110/0", row_n, key_down);
    end
    keys = '0;
    step(1);
    reset = 1'b0;
    step(60);
    checks++;
    if (n_hex - h0 !== 0) begin
      failures++; $display("FAIL rstdeb_no_pulse: got %0d want 0", n_hex - h0);
    end
    checks++;
    if (hexcode !== 4'h0) begin
      failures++; $display("FAIL rstdeb_hexcode: got %h want 0", hexcode);
    end
  endtask

  task automatic test_reset_held();
    int h0;
    bit ok;
    h0 = n_hex;
    keys[0][2] = 1'b1;
    step(60);
    checks++;
    if (n_hex - h0 !== 1 || hexcode !== 4'h2) begin
      failures++; $display("FAIL rsthold_first: count=%0d hexcode=%h want 1/2", n_hex - h0, hexcode);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (hexcode !== 4'h0 || row_n !== 6'b111110) begin
      failures++; $display("FAIL rsthold_reset: hexcode=%h row_n=%b want 0/111110", hexcode, row_n);
    end
    reset = 1'b0;
    step(80);
    checks++;
    if (n_hex - h0 !== 2 || hexcode !== 4'h2 || key_down !== 1'b1) begin
      failures++; $display("FAIL rsthold_reaccept: count=%0d hexcode=%h key_down=%b want 2/2/1", n_hex - h0, hexcode, key_down);
    end
    keys = '0;
    wait_idle(40, ok);
  endtask

  task automatic test_unused_key();
    int p0;
    bit ok;
    p0 = n_hex + n_op + n_eq + n_bs + n_clr;
    keys[5][3] = 1'b1;
    wait_down(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL unused_key_down: got %b want 1", key_down);
    end
    step(100);
    checks++;
    if (key_down !== 1'b1 || (n_hex + n_op + n_eq + n_bs + n_clr) - p0 !== 0) begin
      failures++; $display("FAIL unused_held: key_down=%b pulses=%0d want 1/0", key_down, (n_hex + n_op + n_eq + n_bs + n_clr) - p0);
    end
    keys = '0;
    step(10);
    checks++;
    if (key_down !== 1'b1) begin
      failures++; $display("FAIL unused_early_release: key_down got %b want 1", key_down);
    end
    step(5);
    checks++;
    if (key_down !== 1'b0 || row_n !== 6'b111110) begin
      failures++; $display("FAIL unused_release: key_down=%b row_n=%b want 0/111110", key_down, row_n);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_multi !== 0) begin
      failures++; $display("FAIL one_hot_pulses: got %0d overlap cycles want 0", n_multi);
    end
    checks++;
    if (n_badrow !== 0) begin
      failures++; $display("FAIL row_one_cold: got %0d bad cycles want 0", n_badrow);
    end
  endtask

  initial begin
    reset = 1'b1;
    keys  = '0;
    test_reset();
    test_hex_press();
    test_op_hold();
    test_short_press();
    test_two_keys();
    test_reset_debounce();
    test_reset_held();
    test_unused_key();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
